// File: rtl/ahb3_lite_slave.sv
// AHB3-Lite slave backed by a MEM_DEPTH x 32-bit little-endian word memory.
// Optional macro AHB3LITE_WAIT_STATE_EN inserts one wait state on every legal transfer.
module ahb3_lite_slave #(
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

    state_t        state, state_n;
    logic          active;
    logic [AW+1:0] addr_r;
    logic          write_r;
    logic [1:0]    size_r;
    logic [31:0]   mem [MEM_DEPTH];

    logic          capture, legal, dphase, stall, wr_en;
    logic [3:0]    be;
    logic          unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign capture = HSEL && HREADY && HTRANS[1];
    assign legal   = (HSIZE <= 3'd2)
                  && !(HSIZE == 3'd1 && HADDR[0])
                  && !(HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                  && (HADDR < 32'(MEM_DEPTH * 4));

    // An illegal capture also sets active, but the ERR states keep it out of the data path.
    assign dphase = active && (state == ST_OKAY);

`ifdef AHB3LITE_WAIT_STATE_EN
    logic wait_r;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_r <= 1'b0;
        end else begin
            wait_r <= capture && legal;
        end
    end

    assign stall = dphase && wait_r;
`else
    assign stall = 1'b0;
`endif

    assign wr_en = dphase && write_r && !stall;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_OKAY;
            active  <= 1'b0;
            addr_r  <= '0;
            write_r <= 1'b0;
            size_r  <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                active  <= 1'b1;
                addr_r  <= HADDR[AW+1:0];
                write_r <= HWRITE;
                size_r  <= HSIZE[1:0];
            end else if (!stall) begin
                // A self-inserted wait holds the transfer; any other HREADY=0 cycle drops it.
                active <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            ST_OKAY: begin
                if (capture && !legal) state_n = ST_ERR1;
                if (stall) HREADYOUT = 1'b0;
            end
            ST_ERR1: begin
                state_n   = ST_ERR2;
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                state_n = (capture && !legal) ? ST_ERR1 : ST_OKAY;
                HRESP   = 1'b1;
            end
            default: state_n = ST_OKAY;
        endcase
    end

    always_comb begin
        be = '1;
        case (size_r)
            2'd0: be = 4'b0001 << addr_r[1:0];
            2'd1: be = addr_r[1] ? 4'b1100 : 4'b0011;
            default: be = '1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_r[AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = (dphase && !write_r && !stall) ? mem[addr_r[AW+1:2]] : '0;

endmodule

// File: tb/tb_ahb3_lite_slave.sv
// Bench for ahb3_lite_slave: transfer-level reference model checked every cycle,
// plus directed transfers with hand-computed expectations.
`timescale 1ns/1ps
module tb_ahb3_lite_slave;
    localparam int unsigned MEM_DEPTH = 256;
`ifdef AHB3LITE_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = T_IDLE;
    logic [2:0]  HSIZE = 3'd0, HBURST = 3'd0;
    logic [3:0]  HPROT = 4'b0011;
    logic        HREADY, HREADYOUT, HRESP;
    logic [31:0] HRDATA;

    assign HREADY = HREADYOUT;

    int total = 0;
    int bad   = 0;

    logic        s_ready, s_resp;
    logic [31:0] s_rdata;

    always #5 HCLK = ~HCLK;

    ahb3_lite_slave #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    // Reference model: one pending legal transfer, an error countdown and a byte-tracked memory.
    logic [31:0] mword  [MEM_DEPTH];
    bit   [3:0]  mknown [MEM_DEPTH];
    bit          p_valid = 0;
    bit          p_write = 0;
    int          p_size  = 0;
    int          p_addr  = 0;
    int          p_waits = 0;
    int          err_left = 0;

    function automatic bit e_ready();
        if (err_left == 2) return 1'b0;
        if (p_valid && p_waits > 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit e_resp();
        return err_left > 0;
    endfunction

    function automatic bit e_reading();
        return p_valid && !p_write && p_waits == 0;
    endfunction

    function automatic logic [31:0] e_rdata();
        if (e_reading()) return mword[p_addr / 4];
        return 32'h0;
    endfunction

    function automatic logic [31:0] rd_mask();
        logic [31:0] m;
        m = '1;
        if (e_reading()) begin
            for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{mknown[p_addr / 4][i]}};
        end
        return m;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            p_valid  = 0;
            p_waits  = 0;
            err_left = 0;
        end else begin
            bit rdy;
            rdy = e_ready();
            if (p_valid && rdy) begin
                if (p_write) begin
                    for (int b = 0; b < (1 << p_size); b++) begin
                        int lane;
                        lane = (p_addr % 4) + b;
                        mword[p_addr / 4][8*lane +: 8] = HWDATA[8*lane +: 8];
                        mknown[p_addr / 4][lane] = 1'b1;
                    end
                end
                p_valid = 0;
            end else if (p_valid && p_waits > 0) begin
                p_waits--;
            end
            if (err_left > 0) err_left--;
            if (rdy && HSEL && HTRANS[1]) begin
                if (HSIZE <= 3'd2 && (HADDR & ((32'd1 << HSIZE) - 32'd1)) == 32'd0
                    && HADDR < 32'(MEM_DEPTH * 4)) begin
                    p_valid = 1;
                    p_write = HWRITE;
                    p_size  = int'(HSIZE);
                    p_addr  = int'(HADDR);
                    p_waits = WS;
                end else begin
                    err_left = 2;
                end
            end
        end
    end

    always @(negedge HCLK) begin
        logic [31:0] m;
        m = rd_mask();
        total++;
        if (HREADYOUT !== e_ready() || HRESP !== e_resp() || (HRDATA & m) !== (e_rdata() & m)) begin
            bad++;
            $display("FAIL model @%0t: got ready=%0b resp=%0b rdata=%h, want ready=%0b resp=%0b rdata=%h (mask %h)",
                     $time, HREADYOUT, HRESP, HRDATA, e_ready(), e_resp(), e_rdata(), m);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        HSEL = 1'b1; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd;
        @(negedge HCLK);
        s_ready = HREADYOUT; s_resp = HRESP; s_rdata = HRDATA;
        @(posedge HCLK);
        #1;
    endtask

    // Idle-address cycles until the current data phase completes (bounded).
    task automatic finish_dp(input logic [31:0] wd, output logic [31:0] rd, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        rd    = '0;
        for (int i = 0; i < 4 && !done; i++) begin
            cyc(T_IDLE, 1'b0, 3'd0, 32'h0, wd);
            if (s_ready) begin
                done = 1;
                rd   = s_rdata;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL dp_timeout: got no HREADYOUT within 4 cycles, want completion");
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, output int waits);
        logic [31:0] junk;
        cyc(T_NS, 1'b1, sz, a, 32'h0);
        finish_dp(d, junk, waits);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output int waits);
        cyc(T_NS, 1'b0, 3'd2, a, 32'h0);
        finish_dp(32'h0, d, waits);
    endtask

    task automatic err_seq(input string name, input logic w, input logic [2:0] sz, input logic [31:0] a);
        cyc(T_NS, w, sz, a, 32'h0);
        cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'hFFFF_FFFF);
        lit({name, "_err1"}, {29'h0, s_ready, s_resp, |s_rdata}, {29'h0, 3'b010});
        cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'hFFFF_FFFF);
        lit({name, "_err2"}, {29'h0, s_ready, s_resp, |s_rdata}, {29'h0, 3'b110});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int w;

        @(negedge HCLK);
        lit("reset_ready", {31'h0, HREADYOUT}, 32'h1);
        lit("reset_resp",  {31'h0, HRESP}, 32'h0);
        lit("reset_rdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
        cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
        lit("idle_okay", {30'h0, s_ready, s_resp}, 32'h2);

`ifndef AHB3LITE_WAIT_STATE_EN
        cyc(T_NS, 1'b1, 3'd2, 32'h10, 32'h0);
        cyc(T_NS, 1'b0, 3'd2, 32'h10, 32'hDEAD_BEEF);
        lit("b2b_wr_ready", {31'h0, s_ready}, 32'h1);
        cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
        lit("b2b_rd_data", s_rdata, 32'hDEAD_BEEF);
        lit("b2b_rd_okay", {30'h0, s_ready, s_resp}, 32'h2);
`else
        wr(32'h10, 3'd2, 32'hDEAD_BEEF, w);
        lit("ws_wr_waits", 32'(w), 32'd1);
        rd(32'h10, d, w);
        lit("ws_rd_waits", 32'(w), 32'd1);
        lit("ws_rd_data", d, 32'hDEAD_BEEF);
`endif

        wr(32'h20, 3'd2, 32'h0, w);
        wr(32'h21, 3'd0, 32'h0000_AA00, w);
        wr(32'h22, 3'd1, 32'h1234_0000, w);
        rd(32'h20, d, w);
        lit("lanes_data", d, 32'h1234_AA00);
        lit("lanes_waits", 32'(w), 32'(WS));

        wr(32'h00, 3'd2, 32'h5A5A_5A5A, w);
        err_seq("misalign_rd", 1'b0, 3'd2, 32'h02);
        err_seq("range_wr", 1'b1, 3'd2, 32'(MEM_DEPTH * 4));
        err_seq("size_wr", 1'b1, 3'd3, 32'h10);
        rd(32'h00, d, w);
        lit("err_mem0", d, 32'h5A5A_5A5A);
        rd(32'h10, d, w);
        lit("err_mem10", d, 32'hDEAD_BEEF);

        // Next transfer offered during ERR1 is ignored, re-offered during ERR2 is taken.
        cyc(T_NS, 1'b1, 3'd1, 32'h11, 32'h0);
        cyc(T_NS, 1'b0, 3'd2, 32'h10, 32'hFFFF_FFFF);
        lit("pipe_err1", {30'h0, s_ready, s_resp}, 32'h1);
        cyc(T_NS, 1'b0, 3'd2, 32'h10, 32'hFFFF_FFFF);
        lit("pipe_err2", {30'h0, s_ready, s_resp}, 32'h3);
        finish_dp(32'h0, d, w);
        lit("pipe_rd_data", d, 32'hDEAD_BEEF);

`ifndef AHB3LITE_WAIT_STATE_EN
        HBURST = 3'b011;
        cyc(T_NS,   1'b1, 3'd2, 32'h40, 32'h0);
        cyc(T_SEQ,  1'b1, 3'd2, 32'h44, 32'hA000_0000);
        lit("bw_beat0", {30'h0, s_ready, s_resp}, 32'h2);
        cyc(T_BUSY, 1'b1, 3'd2, 32'h48, 32'hA000_0001);
        lit("bw_beat1", {30'h0, s_ready, s_resp}, 32'h2);
        cyc(T_SEQ,  1'b1, 3'd2, 32'h48, 32'h0BAD_0BAD);
        lit("bw_busy", {30'h0, s_ready, s_resp}, 32'h2);
        cyc(T_SEQ,  1'b1, 3'd2, 32'h4C, 32'hA000_0002);
        cyc(T_IDLE, 1'b0, 3'd0, 32'h0,  32'hA000_0003);
        lit("bw_beat3", {30'h0, s_ready, s_resp}, 32'h2);
        cyc(T_NS,   1'b0, 3'd2, 32'h40, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) cyc(T_SEQ, 1'b0, 3'd2, 32'h40 + 32'(4 * i), 32'h0);
            else       cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
            lit("br_data", s_rdata, 32'hA000_0000 + 32'(i - 1));
            lit("br_ready", {30'h0, s_ready, s_resp}, 32'h2);
        end
        HBURST = 3'b000;
`else
        wr(32'h80, 3'd2, 32'h1111_1111, w);
        cyc(T_NS, 1'b1, 3'd2, 32'h80, 32'h0);
        HTRANS = T_IDLE; HWDATA = 32'h2222_2222;
        @(negedge HCLK);
        lit("rst_wait_ready", {31'h0, HREADYOUT}, 32'h0);
        #1 HRESETn = 1'b0;
        #1;
        lit("rst_async_ready", {31'h0, HREADYOUT}, 32'h1);
        lit("rst_async_resp", {31'h0, HRESP}, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        rd(32'h80, d, w);
        lit("rst_no_commit", d, 32'h1111_1111);
`endif

        cyc(T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
        HSEL = 1'b0;
        @(posedge HCLK); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb3_lite_slave.md
# ahb3_lite_slave

AHB3-Lite memory-backed slave: a single-port, 32-bit, little-endian word memory behind a standard AHB3-Lite slave interface. Supports byte, halfword and word transfers; single and burst transfers are handled as a stream of pipelined address/data phases. Out-of-range, misaligned and oversize accesses get a two-cycle ERROR response. The block sits on the system AHB bus behind the decoder (HSEL) and the HREADY mux; at top level, HREADY is tied to this slave's HREADYOUT.

## Interface
- MEM_DEPTH, 256, memory size in 32-bit words (power of two); valid byte address range is 0 to MEM_DEPTH*4-1.
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  000=byte, 001=halfword, 010=word; others illegal.
- HBURST  in  3  burst type; accepted, not interpreted.
- HPROT  in  4  protection; accepted, not interpreted.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready; the address phase is sampled only when HREADY=1.
- HRDATA  out  32  read data (data phase).
- HREADYOUT  out  1  slave ready; 0 extends the data phase.
- HRESP  out  1  0=OKAY, 1=ERROR.

## Operation
- Address-phase capture: on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ), register HADDR, HWRITE and HSIZE, and set the active flag.
  - If HSEL=0, HTRANS is IDLE or BUSY, or HREADY=0, clear the active flag.
- Legality check, made at capture:
  - ERROR if HSIZE>010.
  - ERROR if the access is misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]≠00.
  - ERROR if HADDR ≥ MEM_DEPTH*4.
- States: OKAY, ERR1, ERR2.
  - OKAY: HREADYOUT=1, HRESP=0.
  - An illegal captured transfer moves OKAY→ERR1. ERR1 drives HREADYOUT=0, HRESP=1.
  - ERR1→ERR2 unconditionally. ERR2 drives HREADYOUT=1, HRESP=1.
  - ERR2→OKAY, or →ERR1 if another illegal transfer is captured.
- Write: in the data phase of a legal write, when HREADYOUT=1, update the memory word at addr[…:2] using byte lanes from addr[1:0] and size:
  - byte: lane addr[1:0];
  - halfword: lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
  - Other lanes are unchanged. Errored writes never modify memory.
- Read: during the data phase of a legal read, HRDATA = full memory word at the registered address, combinational from the array. The master selects lanes.
  - HRDATA=0 outside legal read data phases, including errored reads.
- IDLE and BUSY transfers, and unselected cycles, get a zero-wait OKAY.
- Memory contents are not reset (undefined until written); only control state is reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=OKAY, active flag=0.
- Asserting HRESETn low mid-transfer aborts it immediately; any in-flight write is discarded.
- Legal transfer: zero wait states. Data phase is the cycle after the address phase; write commits on the edge ending that data phase.
- Back-to-back write A then read A: the read returns the new data; no hazard stall.
- Error: two data-phase cycles (ERR1, ERR2). The pipelined next address phase, presented during ERR1, is ignored because HREADY=0. The master may present IDLE or the next transfer during ERR2.
- Burst SEQ beats are handled identically to NONSEQ; no 1 KB boundary checking.

## Configuration
- AHB3LITE_WAIT_STATE_EN defined: every legal NONSEQ/SEQ transfer gets exactly one wait state.
  - First data-phase cycle: HREADYOUT=0, HRESP=0.
  - Second cycle: HREADYOUT=1. Write commits and read data is valid in that cycle.
  - Error responses are unchanged.
- Not defined: zero-wait operation as above.

## Test plan
- Reset: HRESETn=0 → HREADYOUT=1, HRESP=0, HRDATA=0; release, then IDLE cycles → OKAY, HREADYOUT=1.
- Word write 0xDEADBEEF to 0x10, then word read 0x10 back-to-back → HRDATA=0xDEADBEEF, zero wait, HRESP=0.
- After word 0 at 0x20, byte write 0xAA to 0x21 and halfword write 0x1234 to 0x22 → word read 0x20 = 0x1234AA00.
- Word read at 0x02 (misaligned), write at MEM_DEPTH*4 (out of range), HSIZE=011 → each: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
- INCR4 word write burst at 0x40 (NONSEQ + 3 SEQ, with one BUSY inserted), then INCR4 read → data matches, BUSY gets OKAY, no waits.
- With AHB3LITE_WAIT_STATE_EN: single word write/read → one HREADYOUT=0 cycle each, read data correct; async reset during the wait cycle → HREADYOUT=1 immediately and the write is not committed.
